// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the two requesters, the arbiter and the register file.
// The requester side drives master; the arbiter itself uses slave.
interface rf_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);
   logic              wb_stall;
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              reg_write;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wb_src;
   logic              byp_valid;
   logic [CNT_W-1:0]  wr_count;

   modport master (
      output wb_stall, alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      input  alu_ready, mem_ready, reg_write, rd_addr, rd_data, wb_src, byp_valid, wr_count
   );

   modport slave (
      input  wb_stall, alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      output alu_ready, mem_ready, reg_write, rd_addr, rd_data, wb_src, byp_valid, wr_count
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin (or fixed mem-priority) arbiter for the register file's single write port.
// The granted write is registered once and doubles as the forwarding bypass.
module rf_wb_arbiter #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter int FIXED_MEM_PRIO = 0,
   parameter int CNT_W          = 16
) (
   input logic             clk,
   input logic             rst,
   rf_wb_arbiter_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic              last_grant;
   logic              grant_alu;
   logic              grant_mem;
   logic              accepted;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic              reg_write;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wb_src;
   logic [CNT_W-1:0]  wr_count;

   // On contention, the round-robin pointer favours whoever did not win last time.
   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (!rst && !bus.wb_stall) begin
         if (bus.alu_valid && bus.mem_valid) begin
            if (FIXED_MEM_PRIO != 0) begin
               grant_mem = 1'b1;
            end else if (last_grant) begin
               grant_alu = 1'b1;
            end else begin
               grant_mem = 1'b1;
            end
         end else if (bus.alu_valid) begin
            grant_alu = 1'b1;
         end else if (bus.mem_valid) begin
            grant_mem = 1'b1;
         end
      end
   end

   assign accepted = grant_alu | grant_mem;
   assign sel_rd   = grant_mem ? bus.mem_rd   : bus.alu_rd;
   assign sel_data = grant_mem ? bus.mem_data : bus.alu_data;

   // Writes to x0 still update the address/data/source registers but never assert the enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         reg_write  <= 1'b0;
         rd_addr    <= '0;
         rd_data    <= '0;
         wb_src     <= 1'b0;
         wr_count   <= '0;
      end else begin
         reg_write <= accepted && (sel_rd != '0);
         if (accepted) begin
            last_grant <= grant_mem;
            rd_addr    <= sel_rd;
            rd_data    <= sel_data;
            wb_src     <= grant_mem;
            if (sel_rd != '0) begin
               wr_count <= wr_count + CNT_ONE;
            end
         end
      end
   end

   assign bus.alu_ready = grant_alu;
   assign bus.mem_ready = grant_mem;
   assign bus.reg_write = reg_write;
   assign bus.byp_valid = reg_write;
   assign bus.rd_addr   = rd_addr;
   assign bus.rd_data   = rd_data;
   assign bus.wb_src    = wb_src;
   assign bus.wr_count  = wr_count;
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter for the 32x32 register file's single write port. It takes two write-back requesters, the ALU result path and the load/memory return path, and grants one per cycle with round-robin fairness. It drives a registered write (reg_write, rd_addr, rd_data) into the register file and exposes the same write as a bypass for the operand-forwarding logic. Writes to x0 are accepted and then discarded. A stall input freezes all grants.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register address
FIXED_MEM_PRIO, 0, if 1 the mem requester always wins contention (round-robin disabled)
CNT_W, 16, width of retired-write counter

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
wb_stall  input  1  when high, no grants and no write this cycle
alu_valid  input  1  ALU write-back request
alu_ready  output  1  ALU request accepted this cycle
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load write-back request
mem_ready  output  1  load request accepted this cycle
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
reg_write  output  1  register-file write enable (registered)
rd_addr  output  ADDR_W  register-file write address (registered)
rd_data  output  DATA_W  register-file write data (registered)
wb_src  output  1  source of the current write: 0 = ALU, 1 = mem (registered)
byp_valid  output  1  forwarding valid; equals reg_write
wr_count  output  CNT_W  count of register-file writes performed, wraps

Behaviour:
- Reset (rst high at posedge): reg_write=0, rd_addr=0, rd_data=0, wb_src=0, byp_valid=0, wr_count=0, last_grant=1 (mem), so the ALU wins the first contention. While rst is high, alu_ready=0 and mem_ready=0.
- Ready signals are combinational from valid, wb_stall, rst and last_grant. At most one ready is high per cycle. A ready is never high unless its valid is high.
- Grant rules when wb_stall=0 and rst=0:
  - Only one valid: grant that requester.
  - Both valid, FIXED_MEM_PRIO=0: grant the requester that is not last_grant.
  - Both valid, FIXED_MEM_PRIO=1: grant mem.
  - Neither valid: no grant.
- last_grant updates only on an accepted transfer (valid && ready), to the granted source.
- wb_stall=1: both readies are 0. The next cycle has reg_write=0. last_grant and wr_count hold.
- Latency: a request accepted at edge N appears on reg_write/rd_addr/rd_data/wb_src during cycle N+1, which is one register stage.
- x0 handling: an accepted request with rd=0 has reg_write=0 in N+1, and wr_count is not incremented. rd_addr and rd_data still load the accepted values; wb_src updates.
- On an accepted request with rd!=0, reg_write=1 for exactly one cycle and wr_count increments by 1, wrapping from 2^CNT_W-1 to 0.
- In a cycle with no acceptance, reg_write=0 next cycle. rd_addr, rd_data and wb_src hold their last values.
- Requesters must hold valid, rd and data stable until ready. The arbiter does not buffer unaccepted requests.
- Reset mid-transfer: a request presented while rst=1 is not accepted. A write registered in the cycle before reset is still visible for that one cycle, then cleared.
- No internal write-then-read forwarding. Consumers use byp_valid/rd_addr/rd_data.

Test Plan:
- Reset, then ALU-only: alu_rd=3, alu_data=0x0000000A for 1 cycle -> alu_ready=1 that cycle; next cycle reg_write=1, rd_addr=3, rd_data=0xA, wb_src=0, wr_count=1.
- Contention: both valid for 4 cycles, each requester holding a new request after every accept (alu_rd=5, mem_rd=6) -> grant order ALU, mem, ALU, mem; reg_write high 4 consecutive cycles; wr_count=4.
- x0 drop: mem_valid with mem_rd=0, mem_data=0xDEADBEEF -> mem_ready=1; next cycle reg_write=0, wr_count unchanged, wb_src=1.
- Stall: both valid, wb_stall=1 for 3 cycles -> both readies 0 and reg_write 0 throughout. Release stall -> the requester not in last_grant is granted first.
- FIXED_MEM_PRIO=1: both valid for 3 cycles -> mem_ready=1 every cycle, alu_ready stays 0.
- Reset mid-stream: accept at edge N, rst=1 at N+1 -> reg_write=1 during N+1 only; at N+2 all outputs 0, readies 0 while rst high, wr_count=0.
